// File: rtl/div_bcd_formatter.sv
// div_bcd_formatter
//   Sits behind the sequential non-restoring divider. On the rising edge of
//   the divider's done level it captures quotient and remainder, converts
//   each to packed BCD with sequential double-dabble (one bit per clock,
//   quotient first, then remainder) and offers both results on a
//   valid/ready handshake.
//
// Ports
//   clk            rising-edge clock
//   reset          synchronous, active-high reset
//   div_done       divider done level
//   div_quotient   divider quotient (N bits), valid while div_done=1
//   div_remainder  divider remainder (N bits), valid while div_done=1
//   busy           high while converting or holding a result
//   out_valid      BCD results available
//   out_ready      consumer accepts the results
//   q_bcd          packed BCD quotient, digit 0 in bits [3:0]
//   r_bcd          packed BCD remainder
//   overrun        sticky: a done edge arrived while busy and was dropped
module div_bcd_formatter #(
  parameter int N      = 8,
  parameter int DIGITS = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  div_done,
  input  logic [N-1:0]          div_quotient,
  input  logic [N-1:0]          div_remainder,
  output logic                  busy,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [4*DIGITS-1:0]   q_bcd,
  output logic [4*DIGITS-1:0]   r_bcd,
  output logic                  overrun
);

  localparam int BW = 4 * DIGITS;
  localparam int CW = $clog2(N + 1);
  localparam logic [CW-1:0] LAST_BIT = CW'(N - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CONV_Q = 2'd1,
    CONV_R = 2'd2,
    VALID  = 2'd3
  } state_t;

  // Each digit >= 5 gets +3 so that the following shift carries correctly
  // into the next decimal digit. Digits are adjusted independently.
  function automatic logic [BW-1:0] dabble_adjust(input logic [BW-1:0] acc);
    logic [BW-1:0] res;
    res = acc;
    for (int d = 0; d < DIGITS; d++) begin
      if (acc[4*d +: 4] >= 4'd5) begin
        res[4*d +: 4] = acc[4*d +: 4] + 4'd3;
      end
    end
    return res;
  endfunction

  // One double-dabble step: adjust, then shift {bcd, shreg} left by one.
  // The accumulator MSB falls off; it is always zero when 10^DIGITS > 2^N-1.
  function automatic logic [BW+N-1:0] dabble_step(input logic [BW-1:0] acc,
                                                  input logic [N-1:0]  sh);
    logic [BW+N-1:0] cat;
    cat = {dabble_adjust(acc), sh};
    return cat << 1;
  endfunction

  state_t          state_q;
  logic            done_q;
  logic [CW-1:0]   cnt_q;
  logic            busy_q;
  logic            out_valid_q;
  logic            overrun_q;
  logic [BW-1:0]   q_bcd_q;
  logic [BW-1:0]   r_bcd_q;

  // Conversion datapath; not reset, always loaded on capture.
  logic [N-1:0]    qsh_q;
  logic [N-1:0]    rsh_q;
  logic [BW-1:0]   qacc_q;
  logic [BW-1:0]   racc_q;

  logic            rise;
  logic [BW+N-1:0] step_d;
  logic [BW-1:0]   acc_d;
  logic [N-1:0]    sh_d;

  assign rise = div_done & ~done_q;

  // A single step unit is shared: it works on the quotient in CONV_Q and on
  // the remainder in CONV_R.
  always_comb begin
    step_d = '0;
    if (state_q == CONV_R) begin
      step_d = dabble_step(racc_q, rsh_q);
    end else begin
      step_d = dabble_step(qacc_q, qsh_q);
    end
    acc_d = step_d[BW+N-1:N];
    sh_d  = step_d[N-1:0];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      done_q      <= 1'b0;
      cnt_q       <= '0;
      busy_q      <= 1'b0;
      out_valid_q <= 1'b0;
      overrun_q   <= 1'b0;
      q_bcd_q     <= '0;
      r_bcd_q     <= '0;
    end else begin
      done_q <= div_done;

      // Any rise outside IDLE is dropped, including on the accept edge.
      if (rise && (state_q != IDLE)) begin
        overrun_q <= 1'b1;
      end

      case (state_q)
        IDLE: begin
          if (rise) begin
            qsh_q   <= div_quotient;
            rsh_q   <= div_remainder;
            qacc_q  <= '0;
            racc_q  <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= CONV_Q;
          end
        end

        CONV_Q: begin
          qacc_q <= acc_d;
          qsh_q  <= sh_d;
          if (cnt_q == LAST_BIT) begin
            cnt_q   <= '0;
            state_q <= CONV_R;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end

        CONV_R: begin
          racc_q <= acc_d;
          rsh_q  <= sh_d;
          if (cnt_q == LAST_BIT) begin
            // Final remainder step: publish both results on this same edge.
            cnt_q       <= '0;
            q_bcd_q     <= qacc_q;
            r_bcd_q     <= acc_d;
            out_valid_q <= 1'b1;
            state_q     <= VALID;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end

        VALID: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            state_q     <= IDLE;
          end
        end

        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy      = busy_q;
  assign out_valid = out_valid_q;
  assign overrun   = overrun_q;
  assign q_bcd     = q_bcd_q;
  assign r_bcd     = r_bcd_q;

endmodule

// File: tb/tb_div_bcd_formatter.sv
module tb_div_bcd_formatter;

  logic        clk;
  logic        reset;
  logic        div_done;
  logic [7:0]  div_quotient;
  logic [7:0]  div_remainder;
  logic        busy;
  logic        out_valid;
  logic        out_ready;
  logic [11:0] q_bcd;
  logic [11:0] r_bcd;
  logic        overrun;

  int pass_cnt;
  int total_cnt;

  div_bcd_formatter #(.N(8), .DIGITS(3)) dut (
    .clk          (clk),
    .reset        (reset),
    .div_done     (div_done),
    .div_quotient (div_quotient),
    .div_remainder(div_remainder),
    .busy         (busy),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .q_bcd        (q_bcd),
    .r_bcd        (r_bcd),
    .overrun      (overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  q;
    logic [7:0]  r;
    logic [11:0] exp_q;
    logic [11:0] exp_r;
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    total_cnt++;
    if (got === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", name, got, exp);
  endtask

  // Advance one edge, then settle before sampling or driving.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Decimal reference: hundreds, tens, units as BCD nibbles.
  function automatic logic [11:0] bcd3(input int v);
    logic [3:0] h, t, u;
    h = 4'(v / 100);
    t = 4'((v / 10) % 10);
    u = 4'(v % 10);
    return {h, t, u};
  endfunction

  function automatic logic nibbles_ok(input logic [11:0] b);
    return (b[3:0] <= 4'd9) && (b[7:4] <= 4'd9) && (b[11:8] <= 4'd9);
  endfunction

  // Counts edges after the capture edge until out_valid is seen.
  task automatic wait_valid(input int start, output int lat);
    int n;
    n = start;
    while (!out_valid && n < 100) begin
      step();
      n++;
    end
    lat = n;
  endtask

  // Single-cycle done pulse, then wait for the result.
  task automatic convert(input logic [7:0] q, input logic [7:0] r, output int lat);
    div_quotient  = q;
    div_remainder = r;
    div_done      = 1'b1;
    step();                 // E0
    div_done = 1'b0;
    wait_valid(0, lat);
  endtask

  task automatic accept();
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
  endtask

  initial begin
    int lat;
    pass_cnt  = 0;
    total_cnt = 0;

    vecs[0] = '{8'd28,  8'd4,   12'h028, 12'h004};
    vecs[1] = '{8'd255, 8'd0,   12'h255, 12'h000};
    vecs[2] = '{8'd0,   8'd0,   12'h000, 12'h000};
    vecs[3] = '{8'd128, 8'd127, 12'h128, 12'h127};
    vecs[4] = '{8'd200, 8'd55,  12'h200, 12'h055};
    vecs[5] = '{8'd9,   8'd10,  12'h009, 12'h010};
    vecs[6] = '{8'd199, 8'd99,  12'h199, 12'h099};
    vecs[7] = '{8'd64,  8'd250, 12'h064, 12'h250};

    reset = 1'b1; div_done = 1'b0; div_quotient = '0; div_remainder = '0; out_ready = 1'b0;
    step(); step();
    chk("reset_busy", busy, 0);
    chk("reset_valid", out_valid, 0);
    chk("reset_q", q_bcd, 0);
    chk("reset_r", r_bcd, 0);
    chk("reset_overrun", overrun, 0);
    reset = 1'b0;

    // Held done level: exactly one conversion, 16 edges latency.
    div_quotient = 8'd28; div_remainder = 8'd4; div_done = 1'b1;
    step();                 // E0
    chk("hold_busy_after_capture", busy, 1);
    step(); step();         // E1, E2 with done still high
    div_done = 1'b0;
    wait_valid(2, lat);
    chk("hold_latency", lat, 16);
    chk("hold_q", q_bcd, 12'h028);
    chk("hold_r", r_bcd, 12'h004);
    chk("hold_overrun", overrun, 0);
    accept();
    chk("hold_accept_valid", out_valid, 0);
    repeat (3) step();
    chk("hold_no_retrigger", busy, 0);

    // Table of conversions, each accepted immediately.
    for (int i = 0; i < 8; i++) begin
      convert(vecs[i].q, vecs[i].r, lat);
      chk($sformatf("vec%0d_latency", i), lat, 16);
      chk($sformatf("vec%0d_q", i), q_bcd, vecs[i].exp_q);
      chk($sformatf("vec%0d_r", i), r_bcd, vecs[i].exp_r);
      accept();
      chk($sformatf("vec%0d_valid_drop", i), out_valid, 0);
      chk($sformatf("vec%0d_q_held", i), q_bcd, vecs[i].exp_q);
    end

    // Backpressure: results stable for 10 cycles with out_ready low.
    convert(8'd99, 8'd3, lat);
    chk("bp_latency", lat, 16);
    for (int i = 0; i < 10; i++) begin
      step();
      chk($sformatf("bp_valid_%0d", i), out_valid, 1);
      chk($sformatf("bp_q_%0d", i), q_bcd, 12'h099);
      chk($sformatf("bp_r_%0d", i), r_bcd, 12'h003);
    end
    accept();
    chk("bp_accept", out_valid, 0);
    chk("bp_busy", busy, 0);

    // Overrun: second pulse sampled at E5 is dropped.
    div_quotient = 8'd50; div_remainder = 8'd6; div_done = 1'b1;
    step();                 // E0
    div_done = 1'b0;
    repeat (4) step();      // E1..E4
    div_quotient = 8'd77; div_remainder = 8'd77; div_done = 1'b1;
    step();                 // E5
    div_done = 1'b0;
    wait_valid(5, lat);
    chk("ovr_latency", lat, 16);
    chk("ovr_q", q_bcd, 12'h050);
    chk("ovr_r", r_bcd, 12'h006);
    chk("ovr_flag", overrun, 1);
    accept();
    convert(8'd33, 8'd2, lat);
    chk("ovr_next_q", q_bcd, 12'h033);
    chk("ovr_next_r", r_bcd, 12'h002);
    chk("ovr_sticky", overrun, 1);
    accept();

    // Reset mid-conversion, sampled at E8.
    div_quotient = 8'd123; div_remainder = 8'd45; div_done = 1'b1;
    step();                 // E0
    div_done = 1'b0;
    repeat (7) step();      // E1..E7
    reset = 1'b1;
    step();                 // E8
    reset = 1'b0;
    chk("rst_busy", busy, 0);
    chk("rst_valid", out_valid, 0);
    chk("rst_q", q_bcd, 0);
    chk("rst_r", r_bcd, 0);
    chk("rst_overrun", overrun, 0);
    repeat (20) step();
    chk("rst_no_output", out_valid, 0);
    convert(8'd10, 8'd1, lat);
    chk("rst_fresh_latency", lat, 16);
    chk("rst_fresh_q", q_bcd, 12'h010);
    chk("rst_fresh_r", r_bcd, 12'h001);
    accept();

    // Sweep against the decimal model.
    for (int v = 0; v < 256; v++) begin
      logic [7:0] qv, rv;
      qv = 8'(v);
      rv = qv ^ 8'hA5;
      convert(qv, rv, lat);
      chk($sformatf("sweep_q_%0d", v), q_bcd, bcd3(int'(qv)));
      chk($sformatf("sweep_r_%0d", v), r_bcd, bcd3(int'(rv)));
      chk($sformatf("sweep_nib_%0d", v), nibbles_ok(q_bcd) && nibbles_ok(r_bcd), 1);
      accept();
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
